// File: rtl/xosera_bus_master.sv
// rtl/xosera_bus_master.sv - 16-bit request to two-byte Xosera register bus initiator (optional XOSERA_BUS_MASTER_BYTE_EN)
module xosera_bus_master #(
    parameter int SETUP_CYC  = 1,
    parameter int STROBE_CYC = 2,
    parameter int HOLD_CYC   = 1
) (
    input  logic        clk,
    input  logic        reset_n_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_rd_nwr_i,
    input  logic [3:0]  req_reg_num_i,
    input  logic [15:0] req_data_i,
`ifdef XOSERA_BUS_MASTER_BYTE_EN
    input  logic [1:0]  req_bytemask_i,
`endif
    output logic        resp_valid_o,
    output logic [15:0] resp_data_o,
    output logic        busy_o,
    output logic        bus_cs_n_o,
    output logic        bus_rd_nwr_o,
    output logic [3:0]  bus_reg_num_o,
    output logic        bus_bytesel_o,
    output logic [7:0]  bus_data_o,
    output logic        bus_data_oe_o,
    input  logic [7:0]  bus_data_i
);

    localparam int MAX_A = (SETUP_CYC > STROBE_CYC) ? SETUP_CYC : STROBE_CYC;
    localparam int MAX_P = (MAX_A > HOLD_CYC) ? MAX_A : HOLD_CYC;
    localparam int CW    = $clog2(MAX_P) + 1;

    localparam logic [CW-1:0] SETUP_LD  = CW'(SETUP_CYC - 1);
    localparam logic [CW-1:0] STROBE_LD = CW'(STROBE_CYC - 1);
    localparam logic [CW-1:0] HOLD_LD   = CW'(HOLD_CYC - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_STROBE, ST_HOLD} state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           idx_q, idx_d;
    logic           rd_q, rd_d;
    logic [3:0]     reg_q, reg_d;
    logic [15:0]    data_q, data_d;
    logic [1:0]     mask_q, mask_d;
    logic [15:0]    shadow_q, shadow_d;
    logic [1:0]     req_mask;

    logic           resp_valid_d, cs_d, rdnwr_d, sel_d, oe_d;
    logic [15:0]    resp_data_d;
    logic [3:0]     regn_d;
    logic [7:0]     dout_d;

`ifdef XOSERA_BUS_MASTER_BYTE_EN
    assign req_mask = req_bytemask_i;
`else
    assign req_mask = 2'b11;
`endif

    // Sequencing of byte cycles plus the next value of every registered output
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        rd_d         = rd_q;
        reg_d        = reg_q;
        data_d       = data_q;
        mask_d       = mask_q;
        shadow_d     = shadow_q;
        resp_valid_d = 1'b0;
        resp_data_d  = resp_data_o;

        case (state_q)
            ST_IDLE: begin
                if (req_valid_i && req_ready_o) begin
                    rd_d     = req_rd_nwr_i;
                    reg_d    = req_reg_num_i;
                    data_d   = req_data_i;
                    mask_d   = req_mask;
                    shadow_d = 16'h0000;
                    if (req_mask == 2'b00) begin
                        // Empty mask: one dead cycle in HOLD, no bus strobe
                        state_d = ST_HOLD;
                        cnt_d   = '0;
                        idx_d   = 1'b1;
                    end else begin
                        state_d = ST_SETUP;
                        cnt_d   = SETUP_LD;
                        idx_d   = !req_mask[1];
                    end
                end
            end
            ST_SETUP: begin
                if (cnt_q == '0) begin
                    state_d = ST_STROBE;
                    cnt_d   = STROBE_LD;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_STROBE: begin
                if (cnt_q == '0) begin
                    state_d = ST_HOLD;
                    cnt_d   = HOLD_LD;
                    if (rd_q) begin
                        if (idx_q) shadow_d[7:0]  = bus_data_i;
                        else       shadow_d[15:8] = bus_data_i;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_HOLD: begin
                if (cnt_q == '0) begin
                    if (!idx_q && mask_q[0]) begin
                        idx_d   = 1'b1;
                        state_d = ST_SETUP;
                        cnt_d   = SETUP_LD;
                    end else begin
                        state_d      = ST_IDLE;
                        resp_valid_d = 1'b1;
                        resp_data_d  = rd_q ? shadow_q : data_q;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        cs_d    = 1'b1;
        rdnwr_d = bus_rd_nwr_o;
        regn_d  = bus_reg_num_o;
        sel_d   = bus_bytesel_o;
        dout_d  = bus_data_o;
        oe_d    = bus_data_oe_o;
        if (state_d == ST_SETUP || state_d == ST_STROBE) begin
            cs_d    = (state_d != ST_STROBE);
            rdnwr_d = rd_d;
            regn_d  = reg_d;
            sel_d   = idx_d;
            oe_d    = !rd_d;
            if (!rd_d) dout_d = idx_d ? data_d[7:0] : data_d[15:8];
        end else if (state_d == ST_IDLE) begin
            oe_d = 1'b0;
        end
    end

    // State, latched request and registered outputs; reset forces idle bus immediately
    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            idx_q         <= 1'b0;
            rd_q          <= 1'b1;
            reg_q         <= 4'h0;
            data_q        <= 16'h0000;
            mask_q        <= 2'b11;
            shadow_q      <= 16'h0000;
            req_ready_o   <= 1'b1;
            busy_o        <= 1'b0;
            resp_valid_o  <= 1'b0;
            resp_data_o   <= 16'h0000;
            bus_cs_n_o    <= 1'b1;
            bus_rd_nwr_o  <= 1'b1;
            bus_reg_num_o <= 4'h0;
            bus_bytesel_o <= 1'b0;
            bus_data_o    <= 8'h00;
            bus_data_oe_o <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            rd_q          <= rd_d;
            reg_q         <= reg_d;
            data_q        <= data_d;
            mask_q        <= mask_d;
            shadow_q      <= shadow_d;
            req_ready_o   <= (state_d == ST_IDLE);
            busy_o        <= (state_d != ST_IDLE);
            resp_valid_o  <= resp_valid_d;
            resp_data_o   <= resp_data_d;
            bus_cs_n_o    <= cs_d;
            bus_rd_nwr_o  <= rdnwr_d;
            bus_reg_num_o <= regn_d;
            bus_bytesel_o <= sel_d;
            bus_data_o    <= dout_d;
            bus_data_oe_o <= oe_d;
        end
    end

endmodule

// File: doc/xosera_bus_master.md
Name: xosera_bus_master

Overview:
- Host-side initiator for the Xosera 8-bit register bus.
- Converts 16-bit register read/write requests on a valid/ready interface into two byte cycles: even byte first, then odd byte.
- Each byte cycle drives the bus address/control, pulses chip select, and on reads captures returned data.
- Used as the FPGA-side bridge (UART/SPI host bridge) and as the bus driver in block and system benches.

Parameters:
- SETUP_CYC, 1: cycles address/control/write data are stable with cs high before the strobe; minimum 1.
- STROBE_CYC, 2: cycles bus_cs_n_o is held low per byte; minimum 1.
- HOLD_CYC, 1: cycles address/control/write data are held after cs deasserts; minimum 1.

Ports:
- clk  in  1  system clock
- reset_n_i  in  1  reset, asynchronous assert, active-low
- req_valid_i  in  1  request valid
- req_ready_o  out  1  block can accept a request
- req_rd_nwr_i  in  1  0 = write, 1 = read
- req_reg_num_i  in  4  register number
- req_data_i  in  16  write word; [15:8] is the even byte, [7:0] is the odd byte
- resp_valid_o  out  1  one-cycle pulse: transaction complete
- resp_data_o  out  16  read word ([15:8] even byte); held until the next completion
- busy_o  out  1  transaction in progress
- bus_cs_n_o  out  1  register select strobe, active low
- bus_rd_nwr_o  out  1  0 = write, 1 = read
- bus_reg_num_o  out  4  register number
- bus_bytesel_o  out  1  0 = even byte, 1 = odd byte
- bus_data_o  out  8  write byte
- bus_data_oe_o  out  1  drive enable for bus_data_o
- bus_data_i  in  8  read byte from the target

Behaviour:
- Reset values:
  - bus_cs_n_o = 1; bus_rd_nwr_o = 1; bus_reg_num_o = 0; bus_bytesel_o = 0; bus_data_o = 0; bus_data_oe_o = 0.
  - req_ready_o = 1; resp_valid_o = 0; resp_data_o = 0x0000; busy_o = 0.
- All outputs are registered. Reset assertion forces these values immediately (asynchronously), including mid-transaction. No partial response is produced. The cycle after reset release is IDLE.
- States: IDLE, SETUP, STROBE, HOLD.
- Cycle counter:
  - One down-counter, width $clog2 of the largest parameter plus 1.
  - Loaded on each state entry with the parameter minus 1; the state advances when the counter reaches 0.
- IDLE:
  - req_ready_o = 1.
  - On req_valid_i && req_ready_o: latch rd_nwr, reg_num and data; set byte index = 0; go to SETUP. req_ready_o drops the next cycle.
- SETUP:
  - Drive bus_reg_num_o, bus_rd_nwr_o, bus_bytesel_o = byte index.
  - For writes: bus_data_o = the selected byte and bus_data_oe_o = 1.
  - For reads: bus_data_oe_o = 0.
  - bus_cs_n_o = 1.
- STROBE: same as SETUP but bus_cs_n_o = 0. On reads, bus_data_i is sampled at the clock edge ending the last STROBE cycle into the selected byte of the read shadow register.
- HOLD:
  - bus_cs_n_o = 1; address, control and data unchanged.
  - On exit: if byte index = 0, set index = 1 and go to SETUP.
  - Otherwise go to IDLE, pulse resp_valid_o and load resp_data_o from the shadow register.
  - On writes, resp_data_o is loaded with the written word.
- Latency: request accepted at edge k; resp_valid_o is high during cycle k + 2*(SETUP_CYC+STROBE_CYC+HOLD_CYC). With defaults this is k+8.
- req_ready_o is high in the same cycle as resp_valid_o. Back-to-back requests incur no idle cycle beyond that one.
- Between the two bytes, bus_cs_n_o is high for at least HOLD_CYC+SETUP_CYC cycles.
- bus_cs_n_o never glitches low outside STROBE.
- busy_o = !req_ready_o.
- Request inputs are ignored while req_ready_o = 0. req_valid_i may stay high; it is not required to drop.
- bus_data_oe_o = 0 in IDLE, including after write completion.

Optional Feature:
- Macro: XOSERA_BUS_MASTER_BYTE_EN.
- With the macro defined:
  - Extra input req_bytemask_i [1:0]: bit1 = even byte, bit0 = odd byte.
  - Only selected bytes get bus cycles. 2'b10 gives an even-only cycle; 2'b01 gives an odd-only cycle, starting at byte index 1.
  - Latency for a single-byte request is SETUP_CYC+STROBE_CYC+HOLD_CYC.
  - Read bytes not selected return 0x00 in resp_data_o.
  - Mask 2'b00 is accepted and completes in 1 cycle with no bus activity.
- Without the macro: the port is absent and both bytes are always transferred.

Test Plan:
- Write reg 0x3, data 0xA55A, default parameters:
  - Cycle 1: bus_bytesel_o = 0, bus_data_o = 0xA5 in SETUP.
  - Cycles 2-3: cs low.
  - Then bytesel = 1 with data 0x5A, following the same 1/2/1 pattern.
  - resp_valid_o at k+8; bus_data_oe_o = 1 only during the 8 bus cycles.
- Read reg 0x9 with the bench returning 0x12 (even) and 0x34 (odd) during the respective strobes: resp_data_o = 0x1234, bus_data_oe_o stays 0, cs low for exactly 2 cycles per byte.
- Two back-to-back requests with req_valid_i held high:
  - Second request accepted in the same cycle resp_valid_o pulses for the first.
  - Exactly 2 cs pulses per request; 4 total within 18 cycles.
- Assert reset_n_i low during the first STROBE of a write:
  - bus_cs_n_o = 1 and bus_data_oe_o = 0 immediately, without waiting for a clock edge.
  - No resp_valid_o pulse.
  - After release, req_ready_o = 1 and a new read completes normally.
- SETUP_CYC=2, STROBE_CYC=3, HOLD_CYC=1: read completes at k+12; cs low exactly 3 cycles per byte; even data sampled at the end of the 3rd strobe cycle.
- XOSERA_BUS_MASTER_BYTE_EN:
  - Mask 2'b01 write 0x00CC: single odd cycle, bytesel = 1, data 0xCC, resp at k+4.
  - Mask 2'b00: resp at k+1, cs never asserted.
